// File: rtl/gray_frame_writer.sv
// gray_frame_writer: packs 8-bit gray pixels into 32-bit words for the frame buffer.
// Optional GRAY_WRITER_CHECKSUM_EN adds a running checksum of accepted words.
module gray_frame_writer #(
  parameter int IMG_WIDTH         = 300,
  parameter int IMG_HEIGHT        = 300,
  parameter int IMAGE_START_ADDR1 = 0,
  parameter int IMAGE_START_ADDR2 = 22501
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        imageSelector,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic [21:0] address,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done
`ifdef GRAY_WRITER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int TOTAL_PIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int TOTAL_WORDS = (TOTAL_PIX + 3) / 4;
  localparam int PW          = $clog2(TOTAL_PIX + 1);

  typedef logic [PW-1:0] pix_t;

  localparam pix_t        PIX_LAST  = pix_t'(TOTAL_PIX - 1);
  localparam logic [21:0] WORD_LAST = 22'(TOTAL_WORDS - 1);
  localparam logic [21:0] BASE0     = 22'(IMAGE_START_ADDR1);
  localparam logic [21:0] BASE1     = 22'(IMAGE_START_ADDR2);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [21:0] base_q, base_d;
  logic [21:0] word_q, word_d;
  logic [21:0] addr_q, addr_d;
  pix_t        pcnt_q, pcnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] pack_q, pack_d;
  logic [31:0] wdata_q, wdata_d;

  logic go;
  logic take;
  logic word_full;
  logic wr_acc;

  assign go        = (state_q == IDLE) && start;
  assign take      = (state_q == FILL) && pix_valid;
  assign word_full = take && ((lane_q == 2'd3) || (pcnt_q == PIX_LAST));
  assign wr_acc    = (state_q == WRITE) && mem_ready;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      pcnt_q  <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      pcnt_q  <= pcnt_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (word_full) state_d = WRITE;
      WRITE:   if (mem_ready) state_d = (word_q == WORD_LAST) ? DONE : FILL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Packing, counters and the registered write word/address
  always_comb begin
    base_d  = base_q;
    word_d  = word_q;
    addr_d  = addr_q;
    pcnt_d  = pcnt_q;
    lane_d  = lane_q;
    pack_d  = pack_q;
    wdata_d = wdata_q;
    if (go) begin
      base_d = imageSelector ? BASE1 : BASE0;
      word_d = '0;
      pcnt_d = '0;
      lane_d = '0;
      pack_d = '0;
    end
    if (take) begin
      pack_d[{lane_q, 3'b000} +: 8] = pix_data;
      lane_d = lane_q + 2'd1;
      pcnt_d = pcnt_q + pix_t'(1);
    end
    if (word_full) begin
      wdata_d = pack_d;
      addr_d  = base_q + word_q;
    end
    if (wr_acc) begin
      word_d = word_q + 22'd1;
      pack_d = '0;
      lane_d = '0;
    end
  end

  // Outputs decoded from state
  always_comb begin
    pix_ready = (state_q == FILL);
    mem_we    = (state_q == WRITE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  assign address   = addr_q;
  assign mem_wdata = wdata_q;

`ifdef GRAY_WRITER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Running sum of every word the memory accepts
  always_comb begin
    csum_d = csum_q;
    if (go) begin
      csum_d = '0;
    end else if (wr_acc) begin
      csum_d = csum_q + wdata_q;
    end
  end

  // Checksum register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_gray_frame_writer.sv
// tb_gray_frame_writer: random and directed frames on a 5x3 image,
// checked against a word-list model built from the pixel stream.
module tb_gray_frame_writer;

  localparam int W  = 5;
  localparam int H  = 3;
  localparam int TP = W * H;
  localparam int NW = (TP + 3) / 4;
  localparam int A1 = 0;
  localparam int A2 = 22501;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imageSelector;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic [21:0] address;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        busy;
  logic        done;
`ifdef GRAY_WRITER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gray_frame_writer #(
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H),
    .IMAGE_START_ADDR1(A1),
    .IMAGE_START_ADDR2(A2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .imageSelector(imageSelector),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_ready(pix_ready),
    .address(address),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_ready(mem_ready),
    .busy(busy),
    .done(done)
`ifdef GRAY_WRITER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic run_frame(input bit sel, input bit seq, input int pv_pct,
                           input int mr_pct, input bit stall3, input bit noise);
    logic [7:0]  px[$];
    logic [31:0] ew[$];
    logic [21:0] ea[$];
    logic [31:0] sum, d;
    logic [21:0] base;
    int ip, wi, cyc, run, stalls;
    bit fin, acc;
    base = sel ? 22'(A2) : 22'(A1);
    for (int i = 0; i < TP; i++)
      px.push_back(seq ? 8'(8'hA0 + i) : 8'($urandom));
    sum = '0;
    for (int w = 0; w < NW; w++) begin
      d = '0;
      for (int l = 0; l < 4; l++)
        if (4 * w + l < TP) d[8*l +: 8] = px[4*w+l];
      ew.push_back(d);
      ea.push_back(22'(base + 22'(w)));
      sum += d;
    end
    @(negedge clk);
    start = 1'b1;
    imageSelector = sel;
    pix_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", 32'(busy), 1);
    chk("prdy_start", 32'(pix_ready), 1);
    ip = 0; wi = 0; cyc = 1; run = 0; stalls = 0; fin = 0; acc = 0;
    while (!fin && cyc < 4000) begin
      if (acc) chk("we_drop", 32'(mem_we), 0);
      acc = 0;
      if (mem_we) begin
        run++;
        if (wi < NW) begin
          chk("addr", 32'(address), 32'(ea[wi]));
          chk("wdata", mem_wdata, ew[wi]);
        end else begin
          chk("extra_we", 32'(mem_we), 0);
        end
        chk("prdy_in_write", 32'(pix_ready), 0);
      end
      if (stall3 && wi == 0 && mem_we && stalls < 3) begin
        mem_ready = 1'b0;
        stalls++;
      end else begin
        mem_ready = ($urandom_range(99) < mr_pct);
      end
      if (ip < TP) begin
        pix_valid = ($urandom_range(99) < pv_pct);
        pix_data = pix_valid ? px[ip] : 8'($urandom);
      end else begin
        pix_valid = 1'($urandom_range(1));
        pix_data = 8'($urandom);
      end
      if (pix_valid && pix_ready) begin
        if (ip < TP) ip++;
        else chk("pix_overrun", 32'(pix_ready), 0);
      end
      if (noise) begin
        start = 1'($urandom_range(1));
        imageSelector = 1'($urandom_range(1));
      end
      if (mem_we && mem_ready && wi < NW) begin
        wi++;
        if (stall3 && wi == 1) chk("stall_run", run, 4);
        run = 0;
        acc = 1;
        if (wi == NW) fin = 1;
      end
      @(negedge clk);
      cyc++;
    end
    chk("writes", wi, NW);
    start = 1'b0;
    pix_valid = 1'b0;
    mem_ready = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk("busy_done", 32'(busy), 1);
    chk("we_after_last", 32'(mem_we), 0);
    if (pv_pct == 100 && mr_pct == 100 && !stall3)
      chk("done_cycle", cyc, TP + NW + 1);
`ifdef GRAY_WRITER_CHECKSUM_EN
    chk("checksum", checksum, sum);
`endif
    @(negedge clk);
    chk("done_low", 32'(done), 0);
    chk("busy_low", 32'(busy), 0);
`ifdef GRAY_WRITER_CHECKSUM_EN
    chk("checksum_hold", checksum, sum);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    imageSelector = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_prdy", 32'(pix_ready), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(address), 0);
    chk("rst_wdata", mem_wdata, 0);
`ifdef GRAY_WRITER_CHECKSUM_EN
    chk("rst_csum", checksum, 0);
`endif
    rst_n = 1'b1;

    run_frame(1'b0, 1'b1, 100, 100, 1'b0, 1'b0);
    run_frame(1'b1, 1'b1, 100, 100, 1'b0, 1'b1);
    run_frame(1'b0, 1'b1, 100, 100, 1'b1, 1'b0);

    @(negedge clk);
    start = 1'b1;
    imageSelector = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pix_valid = 1'b1;
    pix_data = 8'h11;
    @(negedge clk);
    pix_data = 8'h22;
    @(negedge clk);
    pix_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_prdy", 32'(pix_ready), 0);
    chk("mid_rst_we", 32'(mem_we), 0);
    pix_valid = 1'b1;
    pix_data = 8'h33;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_we", 32'(mem_we), 0);
      chk("idle_prdy", 32'(pix_ready), 0);
    end
    pix_valid = 1'b0;
    run_frame(1'b0, 1'b1, 100, 100, 1'b0, 1'b0);

    for (int f = 0; f < 6; f++)
      run_frame(1'($urandom_range(1)), 1'b0, $urandom_range(100, 30),
                $urandom_range(100, 30), 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
